// File: rtl/vector_dot_product_seq_pkg.sv
// Shared types for the iterative dot-product engine: Q16.16 saturating arithmetic,
// 3-component vectors, and the sequencer state/axis encodings.
package fixed_point;
  localparam int FP_W    = 32;
  localparam int FP_FRAC = 16;

  typedef logic signed [FP_W-1:0] fixed_point_t;

  localparam fixed_point_t FP_MAX = {1'b0, {(FP_W-1){1'b1}}};
  localparam fixed_point_t FP_MIN = {1'b1, {(FP_W-1){1'b0}}};

  typedef struct packed {
    fixed_point_t value;
    logic         overflow;
  } fp_res_t;

  // Product is floored to Q16.16 and saturated when it no longer fits.
  function automatic fp_res_t fixed_point_mul(input fixed_point_t a, input fixed_point_t b);
    logic signed [2*FP_W-1:0]         prod;
    logic [FP_W-FP_FRAC:0]            hi;
    fp_res_t                          r;
    prod       = {{FP_W{a[FP_W-1]}}, a} * {{FP_W{b[FP_W-1]}}, b};
    hi         = prod[2*FP_W-1:FP_W-1+FP_FRAC];
    r.overflow = !((&hi) || (~|hi));
    if (r.overflow) r.value = prod[2*FP_W-1] ? FP_MIN : FP_MAX;
    else            r.value = prod[FP_W-1+FP_FRAC:FP_FRAC];
    return r;
  endfunction

  function automatic fp_res_t fixed_point_add(input fixed_point_t a, input fixed_point_t b);
    logic signed [FP_W:0] sum;
    fp_res_t              r;
    sum        = {a[FP_W-1], a} + {b[FP_W-1], b};
    r.overflow = sum[FP_W] != sum[FP_W-1];
    if (r.overflow) r.value = sum[FP_W] ? FP_MIN : FP_MAX;
    else            r.value = sum[FP_W-1:0];
    return r;
  endfunction
endpackage

package vector;
  import fixed_point::*;

  typedef struct packed {
    fixed_point_t x;
    fixed_point_t y;
    fixed_point_t z;
  } vector_t;

  typedef enum logic [2:0] {IDLE, MUL_X, MUL_Y, MUL_Z, DONE} dot_seq_state_e;
  typedef enum logic [1:0] {AXIS_X, AXIS_Y, AXIS_Z} axis_e;
endpackage

package vector_dot_product_seq_pkg;
  import vector::*;

  localparam int NUM_OPERANDS = 2;

  // The axis being multiplied is a pure function of the sequencer state.
  function automatic axis_e state_axis(input dot_seq_state_e s);
    case (s)
      MUL_Y:   return AXIS_Y;
      MUL_Z:   return AXIS_Z;
      default: return AXIS_X;
    endcase
  endfunction
endpackage

// File: rtl/vector_dot_product_seq_if.sv
// Operand/result handshake bundle between a job producer and the dot-product engine.
interface vector_dot_product_seq_if;
  import fixed_point::*;
  import vector::*;

  logic         in_valid;
  logic         in_ready;
  vector_t      op1;
  vector_t      op2;
  logic         out_valid;
  logic         out_ready;
  fixed_point_t result;
  logic         overflow;
  logic         busy;

  modport master (
    output in_valid, op1, op2, out_ready,
    input  in_ready, out_valid, result, overflow, busy
  );

  modport slave (
    input  in_valid, op1, op2, out_ready,
    output in_ready, out_valid, result, overflow, busy
  );
endinterface

// File: rtl/vector_dot_product_seq_axis_select.sv
// Picks one component of a vector for the shared multiplier.
module vector_axis_select
  import fixed_point::*;
  import vector::*;
(
  input  vector_t      i_vec,
  input  axis_e        i_axis,
  output fixed_point_t o_elem
);
  always_comb begin
    o_elem = i_vec.x;
    case (i_axis)
      AXIS_Y:  o_elem = i_vec.y;
      AXIS_Z:  o_elem = i_vec.z;
      default: o_elem = i_vec.x;
    endcase
  end
endmodule

// File: rtl/vector_dot_product_seq.sv
// Dot product of two 3-vectors using one shared multiplier and one shared adder,
// sequenced x -> y -> z so rounding/saturation order matches the parallel version.
module vector_dot_product_seq
  import fixed_point::*;
  import vector::*;
  import vector_dot_product_seq_pkg::*;
#(
  parameter bit OVERFLOW_HALT = 1'b0
) (
  input logic                     clk,
  input logic                     rst_n,
  vector_dot_product_seq_if.slave bus
);
  dot_seq_state_e r_state, w_state_next;
  vector_t        r_op1, r_op2;
  fixed_point_t   r_acc, w_acc_next;
  logic           r_ovf, w_ovf_next;
  logic           w_accept;
  axis_e          w_axis;
  vector_t        w_ops   [NUM_OPERANDS];
  fixed_point_t   w_elems [NUM_OPERANDS];
  fp_res_t        w_mul, w_add;

  assign w_ops[0] = r_op1;
  assign w_ops[1] = r_op2;
  assign w_axis   = state_axis(r_state);

  generate
    for (genvar gi = 0; gi < NUM_OPERANDS; gi++) begin : g_sel
      vector_axis_select u_sel (
        .i_vec  (w_ops[gi]),
        .i_axis (w_axis),
        .o_elem (w_elems[gi])
      );
    end
  endgenerate

  assign w_mul = fixed_point_mul(w_elems[0], w_elems[1]);
  assign w_add = fixed_point_add(r_acc, w_mul.value);

  // A waiting result frees the engine in the same cycle the consumer takes it.
  assign bus.in_ready  = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.result    = r_acc;
  assign bus.overflow  = r_ovf;

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_ovf_next   = r_ovf;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = MUL_X;
          w_ovf_next   = 1'b0;
        end
      end
      MUL_X: begin
        w_acc_next   = w_mul.value;
        w_ovf_next   = w_mul.overflow;
        w_state_next = (OVERFLOW_HALT && w_mul.overflow) ? DONE : MUL_Y;
      end
      MUL_Y: begin
        w_acc_next   = w_add.value;
        w_ovf_next   = r_ovf | w_mul.overflow | w_add.overflow;
        w_state_next = (OVERFLOW_HALT && w_ovf_next) ? DONE : MUL_Z;
      end
      MUL_Z: begin
        w_acc_next   = w_add.value;
        w_ovf_next   = r_ovf | w_mul.overflow | w_add.overflow;
        w_state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_next = w_accept ? MUL_X : IDLE;
          if (w_accept) w_ovf_next = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op1   <= '0;
      r_op2   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_ovf   <= w_ovf_next;
      if (w_accept) begin
        r_op1 <= bus.op1;
        r_op2 <= bus.op2;
      end
    end
  end
endmodule

// File: tb/tb_vector_dot_product_seq.sv
// Self-checking bench: table vectors, hand-written corner sequences and a random
// stream, all scored through an expected-result queue popped on each output handshake.
module tb_vector_dot_product_seq;
  import fixed_point::*;
  import vector::*;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  vector_dot_product_seq_if vif ();
  vector_dot_product_seq_if hif ();

  vector_dot_product_seq #(.OVERFLOW_HALT(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  vector_dot_product_seq #(.OVERFLOW_HALT(1'b1)) dut_h (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif)
  );

  typedef struct {
    fixed_point_t r;
    logic         o;
  } exp_t;

  typedef struct {
    vector_t      a;
    vector_t      b;
    fixed_point_t er;
    logic         eo;
  } vec_rec_t;

  localparam longint FPMAXL = 2147483647;
  localparam longint FPMINL = -FPMAXL - 1;

  int       checks = 0;
  int       errors = 0;
  int       n_sent = 0;
  int       n_out  = 0;
  exp_t     sb [$];
  exp_t     mon_e;
  vec_rec_t tbl [7];
  bit       stream_done;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic fixed_point_t fp(input real r);
    return fixed_point_t'($rtoi(r * 65536.0));
  endfunction

  function automatic vector_t vec(input fixed_point_t x, input fixed_point_t y, input fixed_point_t z);
    vector_t v;
    v.x = x; v.y = y; v.z = z;
    return v;
  endfunction

  function automatic void clamp(input longint v, output fixed_point_t r, inout logic o);
    if (v > FPMAXL)      begin r = FP_MAX; o = 1'b1; end
    else if (v < FPMINL) begin r = FP_MIN; o = 1'b1; end
    else                 r = fixed_point_t'(v);
  endfunction

  // Parallel reference: three products, then (x + y) + z, every overflow ORed.
  function automatic exp_t ref_dot(input vector_t a, input vector_t b);
    fixed_point_t mx, my, mz, s1, s2;
    logic         o;
    exp_t         e;
    o = 1'b0;
    clamp((longint'(a.x) * longint'(b.x)) >>> 16, mx, o);
    clamp((longint'(a.y) * longint'(b.y)) >>> 16, my, o);
    clamp((longint'(a.z) * longint'(b.z)) >>> 16, mz, o);
    clamp(longint'(mx) + longint'(my), s1, o);
    clamp(longint'(s1) + longint'(mz), s2, o);
    e.r = s2;
    e.o = o;
    return e;
  endfunction

  function automatic fixed_point_t rand_fp();
    case ($urandom_range(0, 7))
      0:       return fixed_point_t'($urandom);
      1:       return FP_MAX;
      2:       return FP_MIN;
      default: return fixed_point_t'($signed($urandom) >>> 11);
    endcase
  endfunction

  // Output side of the scoreboard: every result handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n && vif.out_valid && vif.out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_output: got result %0d, expected no output", vif.result);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_result", vif.result, mon_e.r);
        chk("sb_overflow", vif.overflow, mon_e.o);
      end
    end
  end

  task automatic send(input vector_t a, input vector_t b, input fixed_point_t er, input logic eo);
    int w;
    vif.op1      = a;
    vif.op2      = b;
    vif.in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!vif.in_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!vif.in_ready) begin
      chk("send_in_ready_timeout", vif.in_ready, 1);
    end else begin
      sb.push_back('{r: er, o: eo});
      n_sent++;
    end
    @(posedge clk);
    #1;
    vif.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!vif.out_valid && lat < 20);
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic halt_job(input string name, input vector_t a, input vector_t b, input int exp_lat,
                          input fixed_point_t er, input logic eo);
    int lat;
    hif.op1      = a;
    hif.op2      = b;
    hif.in_valid = 1'b1;
    #1;
    chk({name, "_in_ready"}, hif.in_ready, 1);
    @(posedge clk);
    #1;
    hif.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!hif.out_valid && lat < 20);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_result"}, hif.result, er);
    chk({name, "_overflow"}, hif.overflow, eo);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk({name, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent0, out0;
    vector_t a, b;
    exp_t e;

    tbl[0] = '{vec(fp(1.0), fp(2.0), fp(3.0)),    vec(fp(4.0), fp(5.0), fp(6.0)),    fp(32.0), 1'b0};
    tbl[1] = '{vec(fp(-1.0), fp(-1.0), fp(-1.0)), vec(fp(1.0), fp(1.0), fp(1.0)),    fp(-3.0), 1'b0};
    tbl[2] = '{vec(fp(0.5), fp(0.25), fp(2.0)),   vec(fp(4.0), fp(8.0), fp(-1.0)),   fp(2.0),  1'b0};
    tbl[3] = '{vec(FP_MAX, fp(1.0), fp(1.0)),     vec(FP_MAX, fp(1.0), fp(1.0)),     FP_MAX,   1'b1};
    tbl[4] = '{vec(FP_MIN, 0, 0),                 vec(fp(1.0), 0, 0),                FP_MIN,   1'b0};
    tbl[5] = '{vec(FP_MIN, 0, 0),                 vec(fp(-1.0), 0, 0),               FP_MAX,   1'b1};
    tbl[6] = '{vec(FP_MAX, FP_MAX, 0),            vec(fp(1.0), fp(1.0), 0),          FP_MAX,   1'b1};

    rst_n         = 1'b0;
    vif.in_valid  = 1'b0;
    vif.op1       = '0;
    vif.op2       = '0;
    vif.out_ready = 1'b1;
    hif.in_valid  = 1'b0;
    hif.op1       = '0;
    hif.op2       = '0;
    hif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", vif.in_ready, 1);
    chk("reset_out_valid", vif.out_valid, 0);
    chk("reset_busy", vif.busy, 0);
    chk("reset_result", vif.result, 0);
    chk("reset_overflow", vif.overflow, 0);

    // Basic job: exact 3-cycle latency, then back to idle.
    send(vec(fp(1.0), fp(2.0), fp(3.0)), vec(fp(4.0), fp(5.0), fp(6.0)), fp(32.0), 1'b0);
    wait_out("basic", 3);
    chk("basic_result", vif.result, fp(32.0));
    @(posedge clk);
    #1;
    chk("basic_idle_busy", vif.busy, 0);
    chk("basic_idle_out_valid", vif.out_valid, 0);

    // Backpressure: result held, then same-cycle accept of the next job.
    vif.out_ready = 1'b0;
    send(vec(fp(0.5), fp(0.5), fp(0.5)), vec(fp(2.0), fp(2.0), fp(2.0)), fp(3.0), 1'b0);
    wait_out("bp", 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid_held", vif.out_valid, 1);
      chk("bp_result_held", vif.result, fp(3.0));
      chk("bp_in_ready_low", vif.in_ready, 0);
      @(posedge clk);
      #1;
    end
    vif.op1       = vec(fp(1.0), 0, 0);
    vif.op2       = vec(fp(-2.0), 0, 0);
    vif.in_valid  = 1'b1;
    vif.out_ready = 1'b1;
    #1;
    chk("bp_same_cycle_in_ready", vif.in_ready, 1);
    sb.push_back('{r: fp(-2.0), o: 1'b0});
    n_sent++;
    @(posedge clk);
    #1;
    vif.in_valid = 1'b0;
    wait_out("bp_next", 3);
    chk("bp_next_result", vif.result, fp(-2.0));
    @(posedge clk);
    #1;

    // Overflow without halting runs the full three steps.
    send(vec(FP_MAX, fp(1.0), fp(1.0)), vec(FP_MAX, fp(1.0), fp(1.0)), FP_MAX, 1'b1);
    wait_out("ovf_nohalt", 3);
    chk("ovf_nohalt_flag", vif.overflow, 1);
    @(posedge clk);
    #1;

    halt_job("ovf_halt", vec(FP_MAX, fp(1.0), fp(1.0)), vec(FP_MAX, fp(1.0), fp(1.0)), 1, FP_MAX, 1'b1);
    halt_job("ovf_halt_y", vec(fp(1.0), FP_MAX, fp(1.0)), vec(fp(1.0), fp(2.0), fp(1.0)), 2, FP_MAX, 1'b1);
    halt_job("halt_clean", vec(fp(1.0), fp(2.0), fp(3.0)), vec(fp(4.0), fp(5.0), fp(6.0)), 3, fp(32.0), 1'b0);

    // Table vectors, issued back to back.
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].er, tbl[i].eo);
    end
    drain("table");

    // Random stream with random consumer stalls.
    sent0       = n_sent;
    out0        = n_out;
    stream_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          a = vec(rand_fp(), rand_fp(), rand_fp());
          b = vec(rand_fp(), rand_fp(), rand_fp());
          e = ref_dot(a, b);
          send(a, b, e.r, e.o);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          vif.out_ready = ($urandom_range(0, 3) != 0);
        end
        vif.out_ready = 1'b1;
      end
    join
    drain("random");
    chk("random_jobs_out", n_out - out0, n_sent - sent0);

    // Reset in the middle of a job discards it.
    send(vec(fp(1.0), fp(2.0), fp(3.0)), vec(fp(4.0), fp(5.0), fp(6.0)), fp(32.0), 1'b0);
    @(posedge clk);
    #1;
    chk("midrst_busy_before", vif.busy, 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_in_ready", vif.in_ready, 1);
    chk("midrst_out_valid", vif.out_valid, 0);
    chk("midrst_busy", vif.busy, 0);
    chk("midrst_result", vif.result, 0);
    chk("midrst_overflow", vif.overflow, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_stale_valid", vif.out_valid, 0);
    end
    send(vec(fp(0.5), fp(0.5), fp(0.5)), vec(fp(2.0), fp(2.0), fp(2.0)), fp(3.0), 1'b0);
    wait_out("midrst_new", 3);
    chk("midrst_new_result", vif.result, fp(3.0));
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
